adder_rs_scheduler: RTL and testbench
=====================================

Name: adder_rs_scheduler

Overview:
- Owns the adder's reservation stations (RS) and schedules them onto the single adder unit.
- The instruction queue issues into a free RS. Operands wait for a tag match on the common data bus (CDB).
- Ready RSs are arbitrated round-robin onto the adder. Status pulses (RS_issued, RS_executing_adder, RS_finished) are generated for the instruction queue.
- RS identifiers are one-hot, 6 bits wide, throughout.

Parameters:
- NUM_RS, 6, number of reservation stations; equals the one-hot tag width; fixed at 6.
- DATA_WIDTH, 32, operand/result width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- issue  input  1  allocate an RS this cycle.
- issue_op  input  3  alu_add=000, alu_sub=001, alu_or=100, alu_and=101, alu_not=110, alu_xor=111.
- issue_a_tag  input  6  producer RS of operand A; 0 means issue_a_value is valid.
- issue_a_value  input  DATA_WIDTH  operand A value.
- issue_b_tag  input  6  producer RS of operand B; 0 means value valid.
- issue_b_value  input  DATA_WIDTH  operand B value.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  6  one-hot tag of the broadcasting RS.
- cdb_value  input  DATA_WIDTH  broadcast result.
- adder_available  input  1  adder accepts a dispatch this cycle.
- adder_done  input  1  adder finished an operation.
- adder_done_tag  input  6  one-hot RS of the finished operation.
- adder_RS_available  output  6  one-hot lowest-index free RS; 0 when full.
- issue_error  output  1  issue attempted while full.
- RS_issued  output  6  one-hot pulse: RS allocated.
- adder_start  output  1  dispatch pulse to adder.
- adder_op  output  3  dispatched op.
- adder_a  output  DATA_WIDTH  dispatched operand A.
- adder_b  output  DATA_WIDTH  dispatched operand B.
- RS_executing_adder  output  6  one-hot pulse: dispatched RS; doubles as adder tag.
- RS_finished  output  6  one-hot pulse: RS freed.

Behaviour:
- Per-RS state: FREE -> WAITING -> EXECUTING -> FREE.
  - FREE: busy=0.
  - WAITING: busy, not dispatched.
  - EXECUTING: dispatched, awaiting adder_done.
- Reset: all RS FREE, operand tags and values cleared, round-robin pointer = RS0. All registered outputs 0: issue_error, RS_issued, adder_start, adder_op, adder_a, adder_b, RS_executing_adder, RS_finished.
- adder_RS_available is combinational from registered busy bits: lowest-index FREE slot, one-hot.
  - A slot freed this cycle is not visible until the next cycle.
  - Reads 6'b000001 out of reset.
- Issue, when issue=1 and adder_RS_available!=0:
  - Selected slot -> WAITING; op, tags and values are latched.
  - RS_issued = that slot, registered, next cycle, one-cycle pulse.
- Issue, when issue=1 and full:
  - Nothing is allocated.
  - issue_error=1 for one cycle, next cycle.
- Operand capture:
  - Each WAITING slot with nonzero tag equal to cdb_tag while cdb_valid=1 latches cdb_value and clears that tag.
  - Same-cycle bypass: if the issuing operand tag equals cdb_tag with cdb_valid=1, the slot latches cdb_value with tag 0.
  - Both operands may capture in the same cycle.
- Ready = WAITING and both tags 0, evaluated on registered state. A capture makes the slot eligible the following cycle.
- Dispatch, when adder_available=1 and at least one RS is ready:
  - Choose the first ready slot scanning from the pointer upward, wrapping 5->0.
  - Registered next cycle: adder_start=1, adder_op, adder_a and adder_b from the slot, RS_executing_adder = slot.
  - Slot -> EXECUTING; pointer = slot+1 mod 6.
  - At most one dispatch per cycle.
  - With adder_available=0 or no ready slot: adder_start=0, RS_executing_adder=0; adder_op/adder_a/adder_b hold their last values.
- Completion, when adder_done=1:
  - The EXECUTING slot matching adder_done_tag -> FREE and its fields clear.
  - RS_finished = tag, next cycle, one-cycle pulse.
  - adder_done_tag that is not one-hot, or not EXECUTING, is ignored: no state change, no pulse.
- Simultaneous events in one cycle are all applied independently:
  - issue + dispatch + completion + CDB capture.
  - A freed slot cannot be reallocated in the same cycle.
  - A slot issued this cycle cannot dispatch this cycle.
- Reset asserted mid-operation: all slots return to FREE immediately, in-flight adder results are discarded, and every output returns to its reset value on the next edge.

Test Plan:
- Reset, then issue add A=5 (tag 0), B=7 (tag 0), adder_available=1.
  - Cycle+1: RS_issued=000001. Cycle+2: adder_start=1, RS_executing_adder=000001, adder_a=5, adder_b=7, adder_op=000.
  - adder_done, tag 000001 -> RS_finished=000001 next cycle.
- Six issues with all operand tags = 000001 and no CDB: adder_RS_available steps 000001..100000, then 000000.
  - Seventh issue -> issue_error=1 for one cycle; state unchanged.
- RS0 waits on B tag 000100. cdb_valid with tag 000100, value 0x1234.
  - Dispatch occurs the cycle after the next edge, with adder_b=0x1234.
- Same-cycle bypass: issue A tag 000010 while cdb_valid, cdb_tag=000010, value 9.
  - The slot is ready next cycle; adder_a=9.
- Round-robin: RS0, RS1, RS2 all ready, adder_available toggling 1/0.
  - Dispatch order RS0, RS1, RS2; then a re-readied RS0 wins after RS2.
- Reset asserted while two RS are EXECUTING: all outputs 0 and adder_RS_available=000001 after the edge.
  - A later adder_done for an old tag produces no RS_finished.

Source files
------------

// File: rtl/adder_rs_scheduler.sv
// adder_rs_scheduler
// Owns the adder reservation stations (RS) and schedules ready stations onto
// the single adder unit with a round-robin pointer. RS identifiers are one-hot.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   issue*                 allocate a free RS with op, operand tags and values
//   cdb_*                  common data bus broadcast used for operand capture
//   adder_available        adder accepts a dispatch this cycle
//   adder_done*            adder completion with one-hot RS tag
//   adder_RS_available     lowest-index free RS (combinational), 0 when full
//   issue_error            registered pulse: issue attempted while full
//   RS_issued              registered pulse: RS allocated
//   adder_start/op/a/b     registered dispatch to the adder
//   RS_executing_adder     registered pulse: dispatched RS (adder tag)
//   RS_finished            registered pulse: RS freed
//
// state        | meaning
// RS_FREE      | slot unallocated
// RS_WAITING   | allocated, collecting operands / waiting for dispatch
// RS_EXECUTING | dispatched to the adder, awaiting adder_done
module adder_rs_scheduler #(
  parameter int NUM_RS     = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [2:0]            issue_op,
  input  logic [NUM_RS-1:0]     issue_a_tag,
  input  logic [DATA_WIDTH-1:0] issue_a_value,
  input  logic [NUM_RS-1:0]     issue_b_tag,
  input  logic [DATA_WIDTH-1:0] issue_b_value,
  input  logic                  cdb_valid,
  input  logic [NUM_RS-1:0]     cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_value,
  input  logic                  adder_available,
  input  logic                  adder_done,
  input  logic [NUM_RS-1:0]     adder_done_tag,
  output logic [NUM_RS-1:0]     adder_RS_available,
  output logic                  issue_error,
  output logic [NUM_RS-1:0]     RS_issued,
  output logic                  adder_start,
  output logic [2:0]            adder_op,
  output logic [DATA_WIDTH-1:0] adder_a,
  output logic [DATA_WIDTH-1:0] adder_b,
  output logic [NUM_RS-1:0]     RS_executing_adder,
  output logic [NUM_RS-1:0]     RS_finished
);

  localparam int PTR_W = $clog2(NUM_RS);

  typedef enum logic [1:0] {
    RS_FREE      = 2'd0,
    RS_WAITING   = 2'd1,
    RS_EXECUTING = 2'd2
  } rs_state_e;

  rs_state_e             state_q [NUM_RS];
  rs_state_e             state_d [NUM_RS];
  logic [2:0]            op_q    [NUM_RS];
  logic [2:0]            op_d    [NUM_RS];
  logic [NUM_RS-1:0]     a_tag_q [NUM_RS];
  logic [NUM_RS-1:0]     a_tag_d [NUM_RS];
  logic [NUM_RS-1:0]     b_tag_q [NUM_RS];
  logic [NUM_RS-1:0]     b_tag_d [NUM_RS];
  logic [DATA_WIDTH-1:0] a_val_q [NUM_RS];
  logic [DATA_WIDTH-1:0] a_val_d [NUM_RS];
  logic [DATA_WIDTH-1:0] b_val_q [NUM_RS];
  logic [DATA_WIDTH-1:0] b_val_d [NUM_RS];
  logic [PTR_W-1:0]      ptr_q, ptr_d;

  logic                  issue_error_q, issue_error_d;
  logic [NUM_RS-1:0]     rs_issued_q, rs_issued_d;
  logic                  adder_start_q, adder_start_d;
  logic [2:0]            adder_op_q, adder_op_d;
  logic [DATA_WIDTH-1:0] adder_a_q, adder_a_d;
  logic [DATA_WIDTH-1:0] adder_b_q, adder_b_d;
  logic [NUM_RS-1:0]     rs_exec_q, rs_exec_d;
  logic [NUM_RS-1:0]     rs_finished_q, rs_finished_d;

  logic [NUM_RS-1:0] busy, ready, avail, done_match;
  logic              issue_ok, disp_found, dispatch;
  logic [PTR_W-1:0]  disp_idx;

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      busy[i]  = (state_q[i] != RS_FREE);
      ready[i] = (state_q[i] == RS_WAITING) && (a_tag_q[i] == '0) && (b_tag_q[i] == '0);
      if (!busy[i] && (avail == '0)) avail[i] = 1'b1;
    end
  end

  assign issue_ok = issue && (avail != '0);

  // Round-robin pick: first ready slot at or above the pointer, else the
  // first ready slot below it (wrap-around).
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!disp_found && ready[i] && (PTR_W'(i) >= ptr_q)) begin
        disp_found = 1'b1;
        disp_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (!disp_found && ready[i]) begin
        disp_found = 1'b1;
        disp_idx   = PTR_W'(i);
      end
    end
  end

  assign dispatch = adder_available && disp_found;

  // Malformed or stale completion tags match nothing and are dropped.
  always_comb begin
    done_match = '0;
    if (adder_done && $onehot(adder_done_tag)) begin
      for (int i = 0; i < NUM_RS; i++)
        done_match[i] = adder_done_tag[i] && (state_q[i] == RS_EXECUTING);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      a_tag_d[i] = a_tag_q[i];
      b_tag_d[i] = b_tag_q[i];
      a_val_d[i] = a_val_q[i];
      b_val_d[i] = b_val_q[i];

      if ((state_q[i] == RS_WAITING) && cdb_valid) begin
        if ((a_tag_q[i] != '0) && (a_tag_q[i] == cdb_tag)) begin
          a_val_d[i] = cdb_value;
          a_tag_d[i] = '0;
        end
        if ((b_tag_q[i] != '0) && (b_tag_q[i] == cdb_tag)) begin
          b_val_d[i] = cdb_value;
          b_tag_d[i] = '0;
        end
      end

      if (dispatch && (disp_idx == PTR_W'(i))) state_d[i] = RS_EXECUTING;

      if (done_match[i]) begin
        state_d[i] = RS_FREE;
        op_d[i]    = '0;
        a_tag_d[i] = '0;
        b_tag_d[i] = '0;
        a_val_d[i] = '0;
        b_val_d[i] = '0;
      end

      // avail comes from registered busy bits, so the issuing slot is FREE
      // and cannot collide with the dispatch or completion paths above.
      if (issue_ok && avail[i]) begin
        state_d[i] = RS_WAITING;
        op_d[i]    = issue_op;
        if (cdb_valid && (issue_a_tag != '0) && (issue_a_tag == cdb_tag)) begin
          a_tag_d[i] = '0;
          a_val_d[i] = cdb_value;
        end else begin
          a_tag_d[i] = issue_a_tag;
          a_val_d[i] = issue_a_value;
        end
        if (cdb_valid && (issue_b_tag != '0) && (issue_b_tag == cdb_tag)) begin
          b_tag_d[i] = '0;
          b_val_d[i] = cdb_value;
        end else begin
          b_tag_d[i] = issue_b_tag;
          b_val_d[i] = issue_b_value;
        end
      end
    end
  end

  always_comb begin
    issue_error_d = issue && (avail == '0);
    rs_issued_d   = issue_ok ? avail : '0;
    adder_start_d = dispatch;
    rs_exec_d     = dispatch ? (NUM_RS'(1) << disp_idx) : '0;
    adder_op_d    = dispatch ? op_q[disp_idx]    : adder_op_q;
    adder_a_d     = dispatch ? a_val_q[disp_idx] : adder_a_q;
    adder_b_d     = dispatch ? b_val_q[disp_idx] : adder_b_q;
    rs_finished_d = (done_match != '0) ? adder_done_tag : '0;
    ptr_d         = ptr_q;
    if (dispatch) ptr_d = (disp_idx == PTR_W'(NUM_RS - 1)) ? '0 : disp_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS; i++) begin
        state_q[i] <= RS_FREE;
        op_q[i]    <= '0;
        a_tag_q[i] <= '0;
        b_tag_q[i] <= '0;
        a_val_q[i] <= '0;
        b_val_q[i] <= '0;
      end
      ptr_q         <= '0;
      issue_error_q <= 1'b0;
      rs_issued_q   <= '0;
      adder_start_q <= 1'b0;
      adder_op_q    <= '0;
      adder_a_q     <= '0;
      adder_b_q     <= '0;
      rs_exec_q     <= '0;
      rs_finished_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        a_tag_q[i] <= a_tag_d[i];
        b_tag_q[i] <= b_tag_d[i];
        a_val_q[i] <= a_val_d[i];
        b_val_q[i] <= b_val_d[i];
      end
      ptr_q         <= ptr_d;
      issue_error_q <= issue_error_d;
      rs_issued_q   <= rs_issued_d;
      adder_start_q <= adder_start_d;
      adder_op_q    <= adder_op_d;
      adder_a_q     <= adder_a_d;
      adder_b_q     <= adder_b_d;
      rs_exec_q     <= rs_exec_d;
      rs_finished_q <= rs_finished_d;
    end
  end

  assign adder_RS_available = avail;
  assign issue_error        = issue_error_q;
  assign RS_issued          = rs_issued_q;
  assign adder_start        = adder_start_q;
  assign adder_op           = adder_op_q;
  assign adder_a            = adder_a_q;
  assign adder_b            = adder_b_q;
  assign RS_executing_adder = rs_exec_q;
  assign RS_finished        = rs_finished_q;

endmodule

// File: tb/tb_adder_rs_scheduler.sv
// Directed bench for adder_rs_scheduler: each task drives a scenario and
// checks registered outputs one step after the active edge.
module tb_adder_rs_scheduler;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          issue;
  logic [2:0]    issue_op;
  logic [5:0]    issue_a_tag, issue_b_tag;
  logic [DW-1:0] issue_a_value, issue_b_value;
  logic          cdb_valid;
  logic [5:0]    cdb_tag;
  logic [DW-1:0] cdb_value;
  logic          adder_available, adder_done;
  logic [5:0]    adder_done_tag;
  logic [5:0]    adder_RS_available, RS_issued, RS_executing_adder, RS_finished;
  logic          issue_error, adder_start;
  logic [2:0]    adder_op;
  logic [DW-1:0] adder_a, adder_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  adder_rs_scheduler #(.NUM_RS(6), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .issue(issue), .issue_op(issue_op),
    .issue_a_tag(issue_a_tag), .issue_a_value(issue_a_value),
    .issue_b_tag(issue_b_tag), .issue_b_value(issue_b_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .adder_available(adder_available), .adder_done(adder_done),
    .adder_done_tag(adder_done_tag), .adder_RS_available(adder_RS_available),
    .issue_error(issue_error), .RS_issued(RS_issued), .adder_start(adder_start),
    .adder_op(adder_op), .adder_a(adder_a), .adder_b(adder_b),
    .RS_executing_adder(RS_executing_adder), .RS_finished(RS_finished)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue = 0; issue_op = 0; issue_a_tag = 0; issue_b_tag = 0;
    issue_a_value = 0; issue_b_value = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    adder_available = 0; adder_done = 0; adder_done_tag = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic [5:0] at, input logic [DW-1:0] av,
                             input logic [5:0] bt, input logic [DW-1:0] bv);
    issue = 1; issue_op = op;
    issue_a_tag = at; issue_a_value = av;
    issue_b_tag = bt; issue_b_value = bv;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({issue_error, RS_issued, adder_start, adder_op, adder_a, adder_b, RS_executing_adder, RS_finished} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got err=%b iss=%b st=%b op=%b a=%h b=%h ex=%b fin=%b want all zero",
               issue_error, RS_issued, adder_start, adder_op, adder_a, adder_b, RS_executing_adder, RS_finished);
    end
    vec_cnt++;
    if (adder_RS_available !== 6'b000001) begin
      err_cnt++;
      $display("FAIL reset_avail: got %b want 000001", adder_RS_available);
    end
  endtask

  task automatic test_basic_add();
    do_reset();
    adder_available = 1;
    drive_issue(3'b000, 6'd0, 32'd5, 6'd0, 32'd7);
    step();
    issue = 0;
    vec_cnt++;
    if ({RS_issued, adder_start} !== {6'b000001, 1'b0}) begin
      err_cnt++;
      $display("FAIL basic_issue: got iss=%b st=%b want iss=000001 st=0", RS_issued, adder_start);
    end
    step();
    vec_cnt++;
    if ({adder_start, RS_executing_adder, adder_op, adder_a, adder_b} !== {1'b1, 6'b000001, 3'b000, 32'd5, 32'd7}) begin
      err_cnt++;
      $display("FAIL basic_dispatch: got st=%b ex=%b op=%b a=%0d b=%0d want st=1 ex=000001 op=000 a=5 b=7",
               adder_start, RS_executing_adder, adder_op, adder_a, adder_b);
    end
    step();
    vec_cnt++;
    if ({adder_start, RS_executing_adder, RS_issued} !== '0) begin
      err_cnt++;
      $display("FAIL basic_pulse_end: got st=%b ex=%b iss=%b want zeros", adder_start, RS_executing_adder, RS_issued);
    end
    adder_done = 1; adder_done_tag = 6'b000001;
    step();
    adder_done = 0; adder_done_tag = 0;
    vec_cnt++;
    if (RS_finished !== 6'b000001) begin
      err_cnt++;
      $display("FAIL basic_finished: got %b want 000001", RS_finished);
    end
    step();
    vec_cnt++;
    if ({RS_finished, adder_RS_available} !== {6'b000000, 6'b000001}) begin
      err_cnt++;
      $display("FAIL basic_freed: got fin=%b avail=%b want fin=000000 avail=000001", RS_finished, adder_RS_available);
    end
  endtask

  task automatic test_full();
    logic [5:0] exp_oh;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      exp_oh = 6'(1) << k;
      vec_cnt++;
      if (adder_RS_available !== exp_oh) begin
        err_cnt++;
        $display("FAIL full_avail_%0d: got %b want %b", k, adder_RS_available, exp_oh);
      end
      drive_issue(3'b001, 6'b000001, 32'd0, 6'b000001, 32'd0);
      step();
      issue = 0;
      vec_cnt++;
      if (RS_issued !== exp_oh) begin
        err_cnt++;
        $display("FAIL full_issued_%0d: got %b want %b", k, RS_issued, exp_oh);
      end
    end
    vec_cnt++;
    if (adder_RS_available !== 6'b000000) begin
      err_cnt++;
      $display("FAIL full_avail_empty: got %b want 000000", adder_RS_available);
    end
    drive_issue(3'b000, 6'd0, 32'd1, 6'd0, 32'd1);
    step();
    issue = 0;
    vec_cnt++;
    if ({issue_error, RS_issued} !== {1'b1, 6'b000000}) begin
      err_cnt++;
      $display("FAIL full_error: got err=%b iss=%b want err=1 iss=000000", issue_error, RS_issued);
    end
    step();
    vec_cnt++;
    if ({issue_error, adder_RS_available} !== {1'b0, 6'b000000}) begin
      err_cnt++;
      $display("FAIL full_error_end: got err=%b avail=%b want err=0 avail=000000", issue_error, adder_RS_available);
    end
    // Non-one-hot tag, then a tag naming a slot that is only WAITING.
    adder_done = 1; adder_done_tag = 6'b000011;
    step();
    adder_done_tag = 6'b000001;
    step();
    vec_cnt++;
    if (RS_finished !== 6'b000000) begin
      err_cnt++;
      $display("FAIL done_ignored: got fin=%b want 000000", RS_finished);
    end
    adder_done = 0; adder_done_tag = 0;
    step();
    vec_cnt++;
    if ({RS_finished, adder_RS_available} !== 12'd0) begin
      err_cnt++;
      $display("FAIL done_ignored_state: got fin=%b avail=%b want both 000000", RS_finished, adder_RS_available);
    end
  endtask

  task automatic test_cdb_capture();
    do_reset();
    adder_available = 1;
    drive_issue(3'b000, 6'd0, 32'd1, 6'b000100, 32'd0);
    step();
    issue = 0;
    step();
    vec_cnt++;
    if (adder_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL cdb_no_early_dispatch: got st=%b want 0", adder_start);
    end
    cdb_valid = 1; cdb_tag = 6'b000100; cdb_value = 32'h1234;
    step();
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    vec_cnt++;
    if (adder_start !== 1'b0) begin
      err_cnt++;
      $display("FAIL cdb_capture_cycle: got st=%b want 0", adder_start);
    end
    step();
    vec_cnt++;
    if ({adder_start, RS_executing_adder, adder_a, adder_b} !== {1'b1, 6'b000001, 32'd1, 32'h1234}) begin
      err_cnt++;
      $display("FAIL cdb_dispatch: got st=%b ex=%b a=%h b=%h want st=1 ex=000001 a=1 b=1234",
               adder_start, RS_executing_adder, adder_a, adder_b);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    adder_available = 1;
    drive_issue(3'b111, 6'b000010, 32'd0, 6'd0, 32'd3);
    cdb_valid = 1; cdb_tag = 6'b000010; cdb_value = 32'd9;
    step();
    idle();
    adder_available = 1;
    vec_cnt++;
    if ({RS_issued, adder_start} !== {6'b000001, 1'b0}) begin
      err_cnt++;
      $display("FAIL bypass_issue: got iss=%b st=%b want iss=000001 st=0", RS_issued, adder_start);
    end
    step();
    vec_cnt++;
    if ({adder_start, adder_op, adder_a, adder_b} !== {1'b1, 3'b111, 32'd9, 32'd3}) begin
      err_cnt++;
      $display("FAIL bypass_dispatch: got st=%b op=%b a=%0d b=%0d want st=1 op=111 a=9 b=3",
               adder_start, adder_op, adder_a, adder_b);
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_ex;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_issue(3'b100, 6'd0, 32'(10 + k), 6'd0, 32'd0);
      step();
    end
    issue = 0;
    for (int k = 0; k < 3; k++) begin
      exp_ex = 6'(1) << k;
      adder_available = 1;
      step();
      vec_cnt++;
      if ({adder_start, RS_executing_adder, adder_a} !== {1'b1, exp_ex, 32'(10 + k)}) begin
        err_cnt++;
        $display("FAIL rr_dispatch_%0d: got st=%b ex=%b a=%0d want st=1 ex=%b a=%0d",
                 k, adder_start, RS_executing_adder, adder_a, exp_ex, 10 + k);
      end
      adder_available = 0;
      step();
      vec_cnt++;
      if ({adder_start, RS_executing_adder, adder_a} !== {1'b0, 6'b000000, 32'(10 + k)}) begin
        err_cnt++;
        $display("FAIL rr_hold_%0d: got st=%b ex=%b a=%0d want st=0 ex=000000 a=%0d",
                 k, adder_start, RS_executing_adder, adder_a, 10 + k);
      end
    end
    adder_done = 1; adder_done_tag = 6'b000001;
    step();
    adder_done = 0; adder_done_tag = 0;
    drive_issue(3'b101, 6'd0, 32'd20, 6'd0, 32'd21);
    step();
    issue = 0;
    adder_available = 1;
    step();
    adder_available = 0;
    vec_cnt++;
    if ({adder_start, RS_executing_adder, adder_op, adder_a, adder_b} !== {1'b1, 6'b000001, 3'b101, 32'd20, 32'd21}) begin
      err_cnt++;
      $display("FAIL rr_wrap: got st=%b ex=%b op=%b a=%0d b=%0d want st=1 ex=000001 op=101 a=20 b=21",
               adder_start, RS_executing_adder, adder_op, adder_a, adder_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    adder_available = 1;
    drive_issue(3'b000, 6'd0, 32'd1, 6'd0, 32'd2);
    step();
    drive_issue(3'b001, 6'd0, 32'd3, 6'd0, 32'd4);
    step();
    issue = 0;
    step();
    vec_cnt++;
    if ({RS_executing_adder, adder_a} !== {6'b000010, 32'd3}) begin
      err_cnt++;
      $display("FAIL mid_setup: got ex=%b a=%0d want ex=000010 a=3", RS_executing_adder, adder_a);
    end
    // Reset edge coinciding with a completion and an issue that would otherwise pulse.
    reset = 1;
    adder_done = 1; adder_done_tag = 6'b000001;
    drive_issue(3'b000, 6'd0, 32'd7, 6'd0, 32'd7);
    step();
    reset = 0;
    idle();
    vec_cnt++;
    if ({issue_error, RS_issued, adder_start, adder_op, adder_a, adder_b, RS_executing_adder, RS_finished} !== '0) begin
      err_cnt++;
      $display("FAIL mid_reset_outputs: got err=%b iss=%b st=%b op=%b a=%h b=%h ex=%b fin=%b want all zero",
               issue_error, RS_issued, adder_start, adder_op, adder_a, adder_b, RS_executing_adder, RS_finished);
    end
    vec_cnt++;
    if (adder_RS_available !== 6'b000001) begin
      err_cnt++;
      $display("FAIL mid_reset_avail: got %b want 000001", adder_RS_available);
    end
    adder_done = 1; adder_done_tag = 6'b000010;
    step();
    adder_done = 0; adder_done_tag = 0;
    vec_cnt++;
    if (RS_finished !== 6'b000000) begin
      err_cnt++;
      $display("FAIL mid_stale_done: got fin=%b want 000000", RS_finished);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_basic_add();
    test_full();
    test_cdb_capture();
    test_bypass();
    test_round_robin();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
